// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit:
// FSM states, datapath mux selects, ALU commands and condition codes.
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   typedef struct packed {
      logic       irwrite;
      logic       nextpc;
      logic       regw;
      logic       memw;
      logic       branch;
      logic       aluop;
      logic       adrsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] resultsrc;
   } ctrl_t;

   function automatic ctrl_t ctrl_of(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.irwrite   = 1'b1;
            c.nextpc    = 1'b1;
            c.alusrca   = 1'b1;
            c.alusrcb   = SRCB_FOUR;
            c.resultsrc = RES_ALURES;
         end
         DECODE: begin
            c.alusrca   = 1'b1;
            c.alusrcb   = SRCB_FOUR;
            c.resultsrc = RES_ALURES;
         end
         MEMADR: c.alusrcb = SRCB_IMM;
         MEMRD:  c.adrsrc  = 1'b1;
         MEMWB: begin
            c.resultsrc = RES_RDATA;
            c.regw      = 1'b1;
         end
         MEMWR: begin
            c.adrsrc = 1'b1;
            c.memw   = 1'b1;
         end
         EXECR: c.aluop = 1'b1;
         EXECI: begin
            c.alusrcb = SRCB_IMM;
            c.aluop   = 1'b1;
         end
         ALUWB: begin
            c.resultsrc = RES_ALUOUT;
            c.regw      = 1'b1;
         end
         BRANCH: begin
            c.alusrcb   = SRCB_IMM;
            c.resultsrc = RES_ALURES;
            c.branch    = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic condcheck(logic [3:0] cond,
                                      logic [3:0] f);
      logic n, z, c, v;
      logic r;
      {n, z, c, v} = f;
      case (cond)
         COND_EQ: r = z;
         COND_NE: r = ~z;
         COND_CS: r = c;
         COND_CC: r = ~c;
         COND_MI: r = n;
         COND_PL: r = ~n;
         COND_VS: r = v;
         COND_VC: r = ~v;
         COND_HI: r = c & ~z;
         COND_LS: r = ~c | z;
         COND_GE: r = (n == v);
         COND_LT: r = (n != v);
         COND_GT: r = ~z & (n == v);
         COND_LE: r = z | (n != v);
         COND_AL: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/arm_cond_logic.sv
// Conditional execution: flags register, condex latch and gating of
// the architectural write enables.
module arm_cond_logic
   import arm_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] aluflags,
   input  logic [1:0] flagw,
   input  logic       latch,
   input  logic       pcs,
   input  logic       nextpc,
   input  logic       regw,
   input  logic       memw,
   output logic       pcwrite,
   output logic       regwrite,
   output logic       memwrite
);

   logic [3:0] flags_q;
   logic       condex_q;

   arm_ctrl_flopenr #(.W(2)) u_nz (
      .clk   (clk),
      .reset (reset),
      .en    (flagw[1] & condex_q),
      .d     (aluflags[3:2]),
      .q     (flags_q[3:2])
   );

   arm_ctrl_flopenr #(.W(2)) u_cv (
      .clk   (clk),
      .reset (reset),
      .en    (flagw[0] & condex_q),
      .d     (aluflags[1:0]),
      .q     (flags_q[1:0])
   );

   // Decision is frozen in DECODE and held for the rest of the instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      condex_q <= 1'b0;
      else if (latch) condex_q <= condcheck(cond, flags_q);
   end

   assign pcwrite  = nextpc | (pcs & condex_q);
   assign regwrite = regw & condex_q;
   assign memwrite = memw & condex_q;

endmodule

// File: rtl/arm_ctrl_flopenr.sv
// Enable flop with asynchronous active-high reset to zero.
module arm_ctrl_flopenr #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: main FSM with registered Moore controls,
// ALU decoder and conditional-execution gating.
module arm_multicycle_ctrl
   import arm_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
   input  logic [3:0] aluflags,
   output logic       pcwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       memwrite,
   output logic       adrsrc,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] resultsrc,
   output logic [1:0] immsrc,
   output logic [1:0] regsrc,
   output logic [1:0] alucontrol,
   output logic [3:0] state_o
);

   state_t     state, nxt;
   ctrl_t      c;
   logic [1:0] flagw;
   logic       pcs;

   always_comb begin
      nxt = FETCH;
      case (state)
         FETCH:  nxt = DECODE;
         DECODE: begin
            case (op)
               2'b01:   nxt = MEMADR;
               2'b00:   nxt = funct[5] ? EXECI : EXECR;
               2'b10:   nxt = BRANCH;
               default: nxt = FETCH;
            endcase
         end
         MEMADR: nxt = funct[0] ? MEMRD : MEMWR;
         MEMRD:  nxt = MEMWB;
         EXECR:  nxt = ALUWB;
         EXECI:  nxt = ALUWB;
         default: nxt = FETCH;
      endcase
   end

   // Controls are registered alongside the state so they track it exactly
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         c     <= ctrl_of(FETCH);
      end else begin
         state <= nxt;
         c     <= ctrl_of(nxt);
      end
   end

   always_comb begin
      alucontrol = ALU_ADD;
      flagw      = 2'b00;
      if (c.aluop) begin
         case (funct[4:1])
            4'b0100: begin
               alucontrol = ALU_ADD;
               flagw      = {funct[0], funct[0]};
            end
            4'b0010: begin
               alucontrol = ALU_SUB;
               flagw      = {funct[0], funct[0]};
            end
            4'b0000: begin
               alucontrol = ALU_AND;
               flagw      = {funct[0], 1'b0};
            end
            4'b1100: begin
               alucontrol = ALU_ORR;
               flagw      = {funct[0], 1'b0};
            end
            default: begin
               alucontrol = ALU_ADD;
               flagw      = 2'b00;
            end
         endcase
      end
   end

   assign pcs = ((rd == 4'd15) & c.regw) | c.branch;

   arm_cond_logic u_cond (
      .clk      (clk),
      .reset    (reset),
      .cond     (cond),
      .aluflags (aluflags),
      .flagw    (flagw),
      .latch    (state == DECODE),
      .pcs      (pcs),
      .nextpc   (c.nextpc),
      .regw     (c.regw),
      .memw     (c.memw),
      .pcwrite  (pcwrite),
      .regwrite (regwrite),
      .memwrite (memwrite)
   );

   assign irwrite   = c.irwrite;
   assign adrsrc    = c.adrsrc;
   assign alusrca   = c.alusrca;
   assign alusrcb   = c.alusrcb;
   assign resultsrc = c.resultsrc;
   assign immsrc    = op;
   assign regsrc    = {op == 2'b01, op == 2'b10};
   assign state_o   = state;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Self-checking bench for arm_multicycle_ctrl: instruction-level
// reference model, directed scenarios and randomized instruction stream.
module tb_arm_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] aluflags;
   logic       pcwrite, irwrite, regwrite, memwrite;
   logic       adrsrc, alusrca;
   logic [1:0] alusrcb, resultsrc, immsrc, regsrc, alucontrol;
   logic [3:0] state_o;

   int checks = 0;
   int errors = 0;

   // Model architectural flags {N,Z,C,V}
   logic [3:0] mflags;

   always #5 clk = ~clk;

   arm_multicycle_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .cond       (cond),
      .op         (op),
      .funct      (funct),
      .rd         (rd),
      .aluflags   (aluflags),
      .pcwrite    (pcwrite),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .memwrite   (memwrite),
      .adrsrc     (adrsrc),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .resultsrc  (resultsrc),
      .immsrc     (immsrc),
      .regsrc     (regsrc),
      .alucontrol (alucontrol),
      .state_o    (state_o)
   );

   function automatic logic passes(logic [3:0] cc, logic [3:0] f);
      bit n, z, c, v;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cc)
         0: return z;
         1: return !z;
         2: return c;
         3: return !c;
         4: return n;
         5: return !n;
         6: return v;
         7: return !v;
         8: return c && !z;
         9: return !c || z;
         10: return n == v;
         11: return n != v;
         12: return !z && (n == v);
         13: return z || (n != v);
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Returns -1 for commands the ALU does not support
   function automatic int alu_cmd(logic [5:0] f);
      if (f[4:1] == 4'b0100) return 0;
      if (f[4:1] == 4'b0010) return 1;
      if (f[4:1] == 4'b0000) return 2;
      if (f[4:1] == 4'b1100) return 3;
      return -1;
   endfunction

   function automatic logic [19:0] observed();
      return {pcwrite, irwrite, regwrite, memwrite, adrsrc, alusrca,
              alusrcb, resultsrc, immsrc, regsrc, alucontrol, state_o};
   endfunction

   // Expected bundle for one cycle spent in state s of an instruction
   function automatic logic [19:0] expect_cycle(int s, logic [1:0] o,
         logic [5:0] f, logic [3:0] r, logic ok);
      logic pw, iw, rw, mw, ad, sa;
      logic [1:0] sb, rs, ac;
      int cmd;
      pw = 0; iw = 0; rw = 0; mw = 0; ad = 0; sa = 0;
      sb = 0; rs = 0; ac = 0;
      cmd = alu_cmd(f);
      case (s)
         0: begin iw = 1; pw = 1; sa = 1; sb = 2; rs = 2; end
         1: begin sa = 1; sb = 2; rs = 2; end
         2: sb = 1;
         3: ad = 1;
         4: begin rs = 1; rw = ok; pw = ok && (r == 15); end
         5: begin ad = 1; mw = ok; end
         6: ac = (cmd < 0) ? 2'd0 : 2'(cmd);
         7: begin sb = 1; ac = (cmd < 0) ? 2'd0 : 2'(cmd); end
         8: begin rw = ok; pw = ok && (r == 15); end
         9: begin sb = 1; rs = 2; pw = ok; end
         default: ;
      endcase
      return {pw, iw, rw, mw, ad, sa, sb, rs, o,
              {o == 2'b01, o == 2'b10}, ac, 4'(s)};
   endfunction

   task automatic chk(input string tag, input logic [19:0] obs,
                      input logic [19:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
      end
   endtask

   // Run one whole instruction starting in FETCH, #1 after a posedge
   task automatic run_instr(input string tag, input logic [3:0] cc,
         input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
         input logic [3:0] af);
      int seq[$];
      logic ok;
      int cmd;
      cond = cc; op = o; funct = f; rd = r; aluflags = af;
      ok = passes(cc, mflags);
      cmd = alu_cmd(f);
      seq = '{0, 1};
      case (o)
         2'b01: begin
            seq.push_back(2);
            if (f[0]) begin seq.push_back(3); seq.push_back(4); end
            else seq.push_back(5);
         end
         2'b00: begin
            seq.push_back(f[5] ? 7 : 6);
            seq.push_back(8);
         end
         2'b10: seq.push_back(9);
         default: ;
      endcase
      foreach (seq[i]) begin
         @(negedge clk);
         chk($sformatf("%s.s%0d", tag, seq[i]), observed(),
             expect_cycle(seq[i], o, f, r, ok));
         @(posedge clk);
         #1;
         if ((seq[i] == 6 || seq[i] == 7) && ok && f[0] && cmd >= 0) begin
            mflags[3:2] = af[3:2];
            if (cmd <= 1) mflags[1:0] = af[1:0];
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      cond = 0; op = 0; funct = 0; rd = 0; aluflags = 0;
      mflags = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      run_instr("ldr", 4'b1110, 2'b01, 6'b011001, 4'd2, 4'b0000);
      run_instr("adds", 4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0100);
      run_instr("beq_t", 4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);
      run_instr("adds_z0", 4'b1110, 2'b00, 6'b101001, 4'd3, 4'b0000);
      run_instr("beq_f", 4'b0000, 2'b10, 6'b100000, 4'd0, 4'b1111);
      run_instr("adds_z1", 4'b1110, 2'b00, 6'b001001, 4'd4, 4'b0100);
      run_instr("strne", 4'b0001, 2'b01, 6'b011000, 4'd5, 4'b0000);
      run_instr("sub_pc", 4'b1110, 2'b00, 6'b000100, 4'd15, 4'b0000);
      run_instr("undef", 4'b1110, 2'b11, 6'b111111, 4'd15, 4'b1111);
      run_instr("ldr_pc", 4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000);

      // Abort an ADDS in EXECR that would otherwise set every flag
      run_instr("setz", 4'b1110, 2'b00, 6'b001001, 4'd1, 4'b1111);
      cond = 4'b1110; op = 2'b00; funct = 6'b001001; rd = 4'd1;
      aluflags = 4'b1111;
      repeat (2) @(posedge clk);
      #2;
      chk("pre_reset", {12'h0, state_o}, 20'h00006);
      reset = 1'b1;
      #1;
      chk("async_rst", {pcwrite, irwrite, regwrite, memwrite,
          12'h0, state_o}, {4'b1100, 12'h0, 4'h0});
      @(posedge clk);
      #1;
      reset = 1'b0;
      mflags = 4'b0000;
      run_instr("post_rst_beq", 4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);
      run_instr("post_rst_bcc", 4'b0011, 2'b10, 6'b100000, 4'd0, 4'b0000);

      for (int k = 0; k < 400; k++) begin
         logic [1:0] ro;
         logic [5:0] rf;
         ro = 2'($urandom_range(0, 3));
         rf = 6'($urandom);
         if (k % 3 == 0) begin
            ro = 2'b00;
            rf[0] = 1'b1;
         end
         run_instr($sformatf("rnd%0d", k), 4'($urandom), ro, rf,
                   4'($urandom), 4'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
